multi_clk_divider: RTL and testbench
====================================

MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent tone channels (1..16).
REQ-002 The block SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the in_clk frequency in Hz.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the width of the divider, half-period registers and counters.
REQ-004 The block SHALL have port in_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a frequency load request.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have port cmd_ch, input, $clog2(N_CH) bits (min 1): the target channel.
REQ-009 The block SHALL have port cmd_freq, input, 32 bits: the requested tone frequency in Hz; 0 means silence.
REQ-010 The block SHALL have port ch_en, input, N_CH bits: per-channel run enable.
REQ-011 The block SHALL have port out_clk, output, N_CH bits: per-channel square-wave tone output.
REQ-012 The block SHALL have port ch_active, output, N_CH bits: high when the channel's half-period is nonzero.

Function
REQ-013 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ch and cmd_freq SHALL be captured on that edge.
REQ-014 The command FSM SHALL have states IDLE, DIV and WRITE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 Transitions SHALL be IDLE->DIV on accept; DIV lasts exactly CNT_W cycles (restoring divider, 1 quotient bit/cycle); DIV->WRITE; WRITE->IDLE; accept-to-cmd_ready-high SHALL take CNT_W+2 cycles.
REQ-016 Divider: half = floor((CLK_FREQ_HZ/2) / cmd_freq), with CLK_FREQ_HZ/2 as an elaboration constant; if cmd_freq>0 and half==0, half SHALL clamp to 1; if cmd_freq==0, half=0; quotient overflow of CNT_W SHALL saturate to all-ones.
REQ-017 WRITE SHALL store half into channel cmd_ch's pending register and set its pending flag; other channels SHALL be unaffected.
REQ-018 cmd_ch >= N_CH SHALL be accepted and discarded (FSM runs normally, no register written).
REQ-019 Per channel, when ch_en=0 or active half==0: counter=0, out_clk=0, pending applied immediately.
REQ-020 Otherwise the counter SHALL increment each cycle; when counter==half-1 it SHALL reset to 0, out_clk SHALL toggle and any pending half SHALL become active; out period = 2*half cycles, 50% duty.
REQ-021 A pending update and a toggle on the same edge SHALL apply the new half from the next count; a second command to a channel before its toggle SHALL overwrite the pending value.
REQ-022 ch_active[i] SHALL equal (active half[i] != 0), registered.

Reset
REQ-023 On rst_n=0, asynchronously: FSM=IDLE, cmd_ready=0 while asserted, all half/pending registers=0, counters=0, out_clk=0, ch_active=0.
REQ-024 Reset mid-DIV SHALL abort the command; no channel SHALL be written; cmd_ready SHALL be 1 on the first edge after release.

Configuration
REQ-025 Macro CLK_DIV_PHASE_SYNC_EN: when defined, WRITE SHALL apply half immediately, clear the counter and force out_clk[cmd_ch]=0 (phase restart); when undefined, behaviour per REQ-017/020 (glitch-free, deferred to next toggle).

Verification
REQ-026 CLK_FREQ_HZ=1000, load ch0 freq=100, ch_en=1 -> half=5; out_clk[0] period 10 cycles, 50% duty; cmd_ready low for CNT_W+2 cycles.
REQ-027 CLK_FREQ_HZ=50_000_000, ch1 freq=523 -> half=47801; out_clk[1] toggles every 47801 cycles.
REQ-028 CLK_FREQ_HZ=1000, ch0 at 100 Hz, reload 50 Hz mid-half-period -> current half completes at 5, then half=10 (macro off); with macro on, out_clk[0] drops to 0 at WRITE and restarts.
REQ-029 freq=0 on ch2 -> out_clk[2]=0, ch_active[2]=0; freq=600 with CLK_FREQ_HZ=1000 -> half clamps to 1, output toggles every cycle.
REQ-030 rst_n pulsed low during DIV -> all outputs 0 immediately; target channel unchanged (0); cmd_ready=1 after release.
REQ-031 cmd_valid held high with back-to-back commands to ch0..ch3 -> each accepted only when cmd_ready=1; all four channels run at their loaded frequencies; ch_en[3]=0 holds out_clk[3]=0.

Source files
------------

// File: rtl/multi_clk_divider.sv
// multi_clk_divider
//   N_CH independent square-wave tone generators sharing one command port.
//   A command (cmd_ch, cmd_freq) is turned into a half-period count by a
//   serial restoring divider: half = floor((CLK_FREQ_HZ/2) / cmd_freq),
//   clamped to 1 when the quotient is 0, saturated to all-ones on overflow,
//   and 0 (silence) when cmd_freq is 0.
//
//   Optional feature macro: CLK_DIV_PHASE_SYNC_EN
//     undefined : a new half-period is parked in a pending register and
//                 becomes active at the channel's next toggle (glitch-free).
//     defined   : a new half-period takes effect at once; the channel
//                 counter is cleared and its output forced low.
//
// Ports
//   in_clk      rising-edge clock for all logic
//   rst_n       asynchronous active-low reset
//   cmd_valid   command request
//   cmd_ready   command can be accepted (IDLE only)
//   cmd_ch      target channel; values >= N_CH are accepted and dropped
//   cmd_freq    tone frequency in Hz, 0 = silence
//   ch_en       per-channel run enable
//   out_clk     per-channel tone output
//   ch_active   per-channel "active half-period is nonzero"
//
// Command FSM
//   state | meaning
//   IDLE  | waiting for a command
//   DIV   | CNT_W cycles, one quotient bit per cycle
//   WRITE | result stored into the target channel
//
module multi_clk_divider #(
  parameter int N_CH        = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int CNT_W       = 32,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [31:0]       cmd_freq,
  input  logic [N_CH-1:0]   ch_en,
  output logic [N_CH-1:0]   out_clk,
  output logic [N_CH-1:0]   ch_active
);

  // Dividend extended so that its bits above CNT_W form the initial
  // partial remainder. If that upper part is already >= divisor the
  // quotient cannot fit in CNT_W bits, which is exactly the overflow test.
  localparam int                KW      = CNT_W + 32;
  localparam logic [KW-1:0]     HALF_K  = KW'(CLK_FREQ_HZ / 2);
  localparam logic [31:0]       K_HI    = HALF_K[KW-1:CNT_W];
  localparam logic [CNT_W-1:0]  K_LO    = HALF_K[CNT_W-1:0];
  localparam int                BC_W    = $clog2(CNT_W + 1);
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(CNT_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [31:0]       freq_q, freq_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rem_q, rem_d;
  logic [CNT_W-1:0]  dvd_q, dvd_d;
  logic [CNT_W-1:0]  quot_q, quot_d;
  logic [BC_W-1:0]   bit_q, bit_d;

  logic              wr_en;
  logic [32:0]       r_shift;
  logic [32:0]       r_diff;
  logic              q_bit;
  logic [CNT_W-1:0]  new_half;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    ch_d    = ch_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    bit_d   = bit_q;
    wr_en   = 1'b0;
    r_shift = {rem_q, dvd_q[CNT_W-1]};
    r_diff  = r_shift - {1'b0, freq_q};
    q_bit   = (r_shift >= {1'b0, freq_q});
    case (state_q)
      IDLE: begin
        // ready is registered: it rises one cycle after returning to IDLE
        // and drops on the accept edge itself.
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          state_d = DIV;
          ready_d = 1'b0;
          ch_d    = cmd_ch;
          freq_d  = cmd_freq;
          ovf_d   = (K_HI >= cmd_freq);
          rem_d   = K_HI;
          dvd_d   = K_LO;
          quot_d  = '0;
          bit_d   = BC_LAST;
        end
      end
      DIV: begin
        rem_d  = q_bit ? r_diff[31:0] : r_shift[31:0];
        dvd_d  = dvd_q << 1;
        quot_d = (quot_q << 1) | CNT_W'(q_bit);
        if (bit_q == '0) state_d = WRITE;
        else             bit_d   = bit_q - BC_W'(1);
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (freq_q == '0)        new_half = '0;
    else if (ovf_q)          new_half = '1;
    else if (quot_q == '0)   new_half = CNT_W'(1);
    else                     new_half = quot_q;
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      ch_q    <= '0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ch_q    <= ch_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      bit_q   <= bit_d;
    end
  end

  // Channel datapath
  logic [CNT_W-1:0] half_q [N_CH];
  logic [CNT_W-1:0] half_d [N_CH];
  logic [CNT_W-1:0] pend_q [N_CH];
  logic [CNT_W-1:0] pend_d [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  pvld_q, pvld_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  act_q, act_d;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      half_d[i] = half_q[i];
      pend_d[i] = pend_q[i];
      cnt_d[i]  = cnt_q[i];
      pvld_d[i] = pvld_q[i];
      out_d[i]  = out_q[i];
      if (!ch_en[i] || half_q[i] == '0) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        if (pvld_q[i]) begin
          half_d[i] = pend_q[i];
          pvld_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
        cnt_d[i] = '0;
        out_d[i] = ~out_q[i];
        if (pvld_q[i]) begin
          half_d[i] = pend_q[i];
          pvld_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // The write follows the normal step, so a pending value consumed on
      // this same edge is the old one and the new value waits its turn.
      if (wr_en && int'(ch_q) == i) begin
`ifdef CLK_DIV_PHASE_SYNC_EN
        half_d[i] = new_half;
        pvld_d[i] = 1'b0;
        cnt_d[i]  = '0;
        out_d[i]  = 1'b0;
`else
        pend_d[i] = new_half;
        pvld_d[i] = 1'b1;
`endif
      end
      act_d[i] = (half_d[i] != '0);
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        half_q[i] <= '0;
        pend_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      pvld_q <= '0;
      out_q  <= '0;
      act_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        half_q[i] <= half_d[i];
        pend_q[i] <= pend_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      pvld_q <= pvld_d;
      out_q  <= out_d;
      act_q  <= act_d;
    end
  end

  assign cmd_ready = ready_q;
  assign out_clk   = out_q;
  assign ch_active = act_q;

endmodule

// File: tb/tb_multi_clk_divider.sv
// Testbench for multi_clk_divider.
//   dut   : N_CH=4, CLK_FREQ_HZ=1000, CNT_W=8, checked every cycle against a
//           behavioural model plus literal interval checks.
//   dut_b : N_CH=3, CLK_FREQ_HZ=50_000_000, CNT_W=16, literal checks of a
//           dropped out-of-range command and a 523 Hz tone.
// Honours CLK_DIV_PHASE_SYNC_EN the same way as the design.
module tb_multi_clk_divider;

  localparam int  NA    = 4;
  localparam int  CNT_A = 8;
  localparam longint K_A = 500;

  logic        in_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic [31:0] cmd_freq = '0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  out_clk;
  logic [3:0]  ch_active;

  logic        rst_n_b = 1'b0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_ch = '0;
  logic [31:0] b_freq = '0;
  logic [2:0]  b_en = '0;
  logic [2:0]  b_out;
  logic [2:0]  b_act;

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  chk_on = 1'b0;
  bit  b_done = 1'b0;

  always #5 in_clk = ~in_clk;

  multi_clk_divider #(.N_CH(4), .CLK_FREQ_HZ(1000), .CNT_W(8)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_freq(cmd_freq), .ch_en(ch_en), .out_clk(out_clk),
    .ch_active(ch_active));

  multi_clk_divider #(.N_CH(3), .CLK_FREQ_HZ(50_000_000), .CNT_W(16)) dut_b (
    .in_clk(in_clk), .rst_n(rst_n_b), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_ch(b_ch), .cmd_freq(b_freq), .ch_en(b_en), .out_clk(b_out),
    .ch_active(b_act));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic longint exp_half(input longint k, input longint f, input int w);
    longint q, mx;
    if (f == 0) return 0;
    q  = k / f;
    mx = (longint'(1) << w) - 1;
    if (q == 0) q = 1;
    if (q > mx) q = mx;
    return q;
  endfunction

  // Behavioural model of dut
  bit     m_ready;
  int     m_left;
  bit     m_wr;
  bit     m_do_wr;
  int     m_ch;
  longint m_freq;
  longint m_h;
  longint m_half [NA];
  longint m_pend [NA];
  longint m_el   [NA];
  bit     m_out  [NA];

  initial forever begin
    @(posedge in_clk or negedge rst_n);
    if (!rst_n) begin
      m_ready = 1'b0; m_left = 1; m_wr = 1'b0;
      for (int i = 0; i < NA; i++) begin
        m_half[i] = 0; m_pend[i] = -1; m_el[i] = 0; m_out[i] = 1'b0;
      end
    end else begin
      m_do_wr = 1'b0;
      if (m_ready && cmd_valid) begin
        m_ch = int'(cmd_ch); m_freq = longint'(cmd_freq);
        m_ready = 1'b0; m_left = CNT_A + 2; m_wr = 1'b1;
      end else if (!m_ready) begin
        m_left--;
        if (m_left == 1 && m_wr) begin m_do_wr = 1'b1; m_wr = 1'b0; end
        if (m_left <= 0) m_ready = 1'b1;
      end
      for (int i = 0; i < NA; i++) begin
        if (!ch_en[i] || m_half[i] == 0) begin
          m_el[i] = 0; m_out[i] = 1'b0;
          if (m_pend[i] >= 0) begin m_half[i] = m_pend[i]; m_pend[i] = -1; end
        end else begin
          m_el[i]++;
          if (m_el[i] == m_half[i]) begin
            m_el[i] = 0; m_out[i] = !m_out[i];
            if (m_pend[i] >= 0) begin m_half[i] = m_pend[i]; m_pend[i] = -1; end
          end
        end
      end
      if (m_do_wr && m_ch < NA) begin
        m_h = exp_half(K_A, m_freq, CNT_A);
`ifdef CLK_DIV_PHASE_SYNC_EN
        m_half[m_ch] = m_h; m_pend[m_ch] = -1; m_el[m_ch] = 0; m_out[m_ch] = 1'b0;
`else
        m_pend[m_ch] = m_h;
`endif
      end
    end
  end

  logic [3:0] e_out, e_act;
  initial forever begin
    @(negedge in_clk);
    if (chk_on) begin
      for (int i = 0; i < NA; i++) begin
        e_out[i] = m_out[i];
        e_act[i] = (m_half[i] != 0);
      end
      check("model_cmd_ready", 64'(cmd_ready), 64'(m_ready));
      check("model_out_clk", 64'(out_clk), 64'(e_out));
      check("model_ch_active", 64'(ch_active), 64'(e_act));
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int ch, input int f, input bit keep);
    int n;
    cmd_ch = ch[1:0]; cmd_freq = f; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge in_clk); n++; end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    @(negedge in_clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge in_clk); n++; end
    if (n >= 200) check("ready_timeout", 64'(n), 64'(0));
  endtask

  task automatic measure(input int idx, output int n);
    logic v;
    v = out_clk[idx]; n = 0;
    do begin @(negedge in_clk); n++; end while (out_clk[idx] === v && n < 2000);
  endtask

  initial begin : main
    int n, f, ch;
    ch_en = 4'b0111;
    repeat (3) @(negedge in_clk);
    check("rst_ready", 64'(cmd_ready), 64'(0));
    check("rst_out", 64'(out_clk), 64'(0));
    check("rst_active", 64'(ch_active), 64'(0));
    chk_on = 1'b1;
    @(posedge in_clk); #2 rst_n = 1'b1;
    @(negedge in_clk);
    @(negedge in_clk);
    check("ready_after_release", 64'(cmd_ready), 64'(1));

    // 100 Hz on ch0: half 5, ready low CNT_W+2 cycles
    send(0, 100, 1'b0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin n++; @(negedge in_clk); end
    check("ready_low_cycles", 64'(n), 64'(CNT_A + 2));
    measure(0, n);
    measure(0, n); check("ch0_100hz_half_a", 64'(n), 64'(5));
    measure(0, n); check("ch0_100hz_half_b", 64'(n), 64'(5));

    // reload 50 Hz mid half-period
    send(0, 50, 1'b0);
    wait_ready();
    measure(0, n);
    measure(0, n); check("ch0_50hz_half_a", 64'(n), 64'(10));
    measure(0, n); check("ch0_50hz_half_b", 64'(n), 64'(10));

    // clamp to 1, then silence
    send(2, 600, 1'b0);
    wait_ready();
    repeat (2) @(negedge in_clk);
    measure(2, n); check("ch2_clamp_a", 64'(n), 64'(1));
    measure(2, n); check("ch2_clamp_b", 64'(n), 64'(1));
    send(2, 0, 1'b0);
    wait_ready();
    repeat (2) @(negedge in_clk);
    check("ch2_silent_out", 64'(out_clk[2]), 64'(0));
    check("ch2_silent_active", 64'(ch_active[2]), 64'(0));

    // quotient 500 saturates to 255 in 8 bits
    send(1, 1, 1'b0);
    wait_ready();
    repeat (2) @(negedge in_clk);
    measure(1, n);
    measure(1, n); check("ch1_saturate", 64'(n), 64'(255));

    // reset during DIV
    @(posedge in_clk); #2 rst_n = 1'b0;
    repeat (5) @(negedge in_clk);
    @(posedge in_clk); #2 rst_n = 1'b1;
    @(negedge in_clk);
    send(3, 100, 1'b0);
    repeat (3) @(negedge in_clk);
    @(posedge in_clk); #2 rst_n = 1'b0;
    #1;
    check("middiv_rst_out", 64'(out_clk), 64'(0));
    check("middiv_rst_active", 64'(ch_active), 64'(0));
    check("middiv_rst_ready", 64'(cmd_ready), 64'(0));
    repeat (2) @(negedge in_clk);
    @(posedge in_clk); #2 rst_n = 1'b1;
    @(negedge in_clk);
    @(negedge in_clk);
    check("middiv_ready_after", 64'(cmd_ready), 64'(1));
    ch_en = 4'b1111;
    repeat (15) @(negedge in_clk);
    check("middiv_no_write", 64'(ch_active), 64'(0));

    // back-to-back with cmd_valid held high, ch3 disabled
    ch_en = 4'b0111;
    send(0, 100, 1'b1);
    send(1, 250, 1'b1);
    send(2, 125, 1'b1);
    send(3, 50, 1'b0);
    wait_ready();
    repeat (30) @(negedge in_clk);
    check("b2b_ch3_out", 64'(out_clk[3]), 64'(0));
    check("b2b_ch3_active", 64'(ch_active[3]), 64'(1));
    measure(1, n);
    measure(1, n); check("b2b_ch1_half", 64'(n), 64'(2));
    measure(2, n);
    measure(2, n); check("b2b_ch2_half", 64'(n), 64'(4));

    // randomized traffic, model-checked every cycle
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) ch_en = 4'($urandom);
      ch = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       f = 0;
        1:       f = $urandom_range(400, 1000);
        default: f = $urandom_range(25, 400);
      endcase
      send(ch, f, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 12)) @(negedge in_clk);
    end
    cmd_valid = 1'b0;
    ch_en = 4'b1111;
    repeat (60) @(negedge in_clk);

    n = 0;
    while (!b_done && n < 60000) begin @(negedge in_clk); n++; end
    if (!b_done) check("b_timeout", 64'(0), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : side_b
    int n;
    b_en = 3'b101;
    repeat (3) @(negedge in_clk);
    @(posedge in_clk); #2 rst_n_b = 1'b1;
    repeat (2) @(negedge in_clk);
    // cmd_ch=3 is out of range for 3 channels: accepted and dropped
    b_ch = 2'd3; b_freq = 32'd1000; b_valid = 1'b1;
    n = 0;
    while (b_ready !== 1'b1 && n < 100) begin @(negedge in_clk); n++; end
    @(negedge in_clk);
    b_valid = 1'b0;
    n = 0;
    while (b_ready !== 1'b1 && n < 100) begin @(negedge in_clk); n++; end
    check("b_discard_ready", 64'(b_ready), 64'(1));
    repeat (3) @(negedge in_clk);
    check("b_discard_active", 64'(b_act), 64'(0));
    check("b_discard_out", 64'(b_out), 64'(0));
    b_ch = 2'd1; b_freq = 32'd523; b_valid = 1'b1;
    @(negedge in_clk);
    b_valid = 1'b0;
    n = 0;
    while (b_ready !== 1'b1 && n < 100) begin @(negedge in_clk); n++; end
    repeat (3) @(negedge in_clk);
    check("b_523_active", 64'(b_act), 64'(3'b010));
    b_en = 3'b111;
    n = 0;
    do begin @(negedge in_clk); n++; end while (b_out[1] !== 1'b1 && n < 60000);
    check("b_523_half", 64'(n), 64'(47801));
    check("b_523_out", 64'(b_out), 64'(3'b010));
    b_done = 1'b1;
  end

endmodule
